// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// ready-handshake memory port, holds it in the instruction register and steps
// the PC (sequential / branch / jump) when the execute slot completes.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic             stall,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Low address bits are forced to zero so the PC can never go unaligned.
  localparam logic [31:0]      PC_INIT  = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_next;
  logic        load_instr;
  logic        advance;
  logic [31:0] next_pc;

  // Pseudo-direct jump: region bits from the sequential PC, word index from the instruction.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] ins);
    return {pc4[31:28], ins[25:0], 2'b00};
  endfunction

  // PC-relative branch: sign-extended word offset added to the sequential PC, wrapping mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] ins);
    return pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
  endfunction

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Next-PC selection; jump overrides a simultaneously taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target(pc_plus4, instr);
    end else if (branch_taken) begin
      next_pc = branch_target(pc_plus4, instr);
    end
  end

  // FSM next-state and handshake outputs; request is gated by reset so it drops immediately.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    advance     = 1'b0;
    case (state)
      FETCH: begin
        imem_req = rst_n;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register, PC and retire counter; all frozen while the execute slot stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= 32'h0000_0000;
      pc      <= PC_INIT;
      retired <= '0;
    end else begin
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (advance) begin
        pc      <= next_pc;
        retired <= retired + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences, a table of
// branch/jump cases, and randomized traffic against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump;
  logic        branch_taken;
  logic        stall;
  logic [31:0] retired;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .branch_taken (branch_taken),
    .stall        (stall),
    .retired      (retired)
  );

  int checks = 0;
  int errors = 0;

  // Model: the instruction currently held, where it lives, and whether it is awaiting execution.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_retired;
  logic        exp_valid;

  // Values to drive on the next cycle.
  logic        rst_d;
  logic        ready_d;
  logic [31:0] rdata_d;
  logic        jump_d;
  logic        br_d;
  logic        stall_d;

  int req_seen;
  int valid_seen;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] ins;
    logic        j;
    logic        b;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic j, input logic b);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b) return p4 + off * 32'd4;
    return p4;
  endfunction

  task automatic model_reset();
    exp_pc      = RST_PC;
    exp_instr   = 32'h0;
    exp_retired = 32'h0;
    exp_valid   = 1'b0;
  endtask

  task automatic check_all();
    chk1("imem_req", imem_req, rst_n & ~exp_valid);
    chk1("instr_valid", instr_valid, exp_valid);
    chk("pc", pc, exp_pc);
    chk("imem_addr", imem_addr, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("instr", instr, exp_instr);
    chk("retired", retired, exp_retired);
    if (imem_req === 1'b1) req_seen++;
    if (instr_valid === 1'b1) valid_seen++;
  endtask

  // One clock: check at the falling edge, drive, then advance the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    rst_n        = rst_d;
    imem_ready   = ready_d;
    imem_rdata   = rdata_d;
    jump         = jump_d;
    branch_taken = br_d;
    stall        = stall_d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (exp_valid) begin
      if (!stall) begin
        exp_pc      = model_next(exp_pc, exp_instr, jump, branch_taken);
        exp_retired = exp_retired + 32'd1;
        exp_valid   = 1'b0;
      end
    end else if (imem_ready) begin
      exp_instr = imem_rdata;
      exp_valid = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ready_d = 1'b0;
    jump_d  = 1'b0;
    br_d    = 1'b0;
    stall_d = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] word, input logic j, input logic b,
                           input int waits, input int stalls);
    idle_inputs();
    for (int i = 0; i < waits; i++) tick();
    ready_d = 1'b1;
    rdata_d = word;
    tick();
    ready_d = 1'b0;
    stall_d = 1'b1;
    for (int i = 0; i < stalls; i++) tick();
    stall_d = 1'b0;
    jump_d  = j;
    br_d    = b;
    tick();
    idle_inputs();
  endtask

  task automatic goto_pc(input logic [31:0] target);
    run_instr({6'b000010, target[27:2]}, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] w;

    tbl[0] = '{32'h0000_0100, 32'h1000_FFFE, 1'b0, 1'b1, 32'h0000_00FC};
    tbl[1] = '{32'h0000_0100, 32'h1000_0003, 1'b0, 1'b1, 32'h0000_0110};
    tbl[2] = '{32'h0040_0010, 32'h0810_0000, 1'b1, 1'b1, 32'h0040_0000};
    tbl[3] = '{32'h0000_0200, 32'h1000_0003, 1'b0, 1'b0, 32'h0000_0204};
    tbl[4] = '{32'h0000_0008, 32'h0800_0040, 1'b1, 1'b0, 32'h0000_0100};
    tbl[5] = '{32'h0FFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 32'h1000_0000};

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    rst_d = 1'b0; rdata_d = 32'h0;
    idle_inputs();
    model_reset();
    req_seen = 0; valid_seen = 0;

    // Power-on reset, then release
    tick();
    tick();
    rst_d = 1'b1;
    tick();

    // Sequential fetch with zero wait states from address 0
    goto_pc(32'h0);
    valid_seen = 0;
    ready_d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdata_d = 32'h2000_0000 | exp_pc;
      tick();
    end
    ready_d = 1'b0;
    chk("seq_valid_count", valid_seen, 32'd3);
    chk("seq_pc", pc, 32'h0000_000C);
    chk("seq_retired", retired, 32'd4);
    chk1("seq_req_after", imem_req, 1'b1);

    // Three memory wait states at 0x10
    goto_pc(32'h0000_0010);
    req_seen = 0;
    ready_d = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    w = 32'h2108_ABCD;
    ready_d = 1'b1;
    rdata_d = w;
    tick();
    ready_d = 1'b0;
    chk("wait_req_cycles", req_seen, 32'd4);
    chk("wait_instr", instr, w);
    chk1("wait_valid", instr_valid, 1'b1);
    tick();

    // Five stall cycles in the execute slot
    w = 32'h1000_0005;
    ready_d = 1'b1;
    rdata_d = w;
    tick();
    ready_d = 1'b0;
    r0 = exp_retired;
    stall_d = 1'b1;
    jump_d  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_retired", retired, r0);
    chk("stall_instr", instr, w);
    chk1("stall_req", imem_req, 1'b0);
    stall_d = 1'b0;
    jump_d  = 1'b0;
    tick();
    chk("stall_release_retired", retired, r0 + 32'd1);
    chk1("stall_release_req", imem_req, 1'b1);
    chk1("stall_release_valid", instr_valid, 1'b0);

    // PC wrap from 0xFFFF_FFFC back to 0
    goto_pc(32'h0);
    run_instr(32'h1000_FFFE, 1'b0, 1'b1, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    run_instr(32'h0, 1'b0, 1'b0, 0, 0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Branch / jump table
    foreach (tbl[k]) begin
      goto_pc(tbl[k].start_pc);
      chk("tbl_setup_pc", pc, tbl[k].start_pc);
      run_instr(tbl[k].ins, tbl[k].j, tbl[k].b, $urandom_range(0, 2), $urandom_range(0, 2));
      chk("tbl_next_addr", imem_addr, tbl[k].exp_next);
    end

    // Asynchronous reset in the middle of a pending fetch
    ready_d = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    rst_d = 1'b0;
    #1;
    model_reset();
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_retired", retired, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    ready_d = 1'b1;
    rdata_d = 32'hDEAD_BEEF;
    tick();
    tick();
    rst_d   = 1'b1;
    ready_d = 1'b0;
    tick();
    run_instr(32'h2000_0001, 1'b0, 1'b0, 1, 0);
    chk("post_rst_addr", imem_addr, RST_PC + 32'd4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      ready_d = ($urandom_range(0, 3) != 0);
      rdata_d = $urandom;
      jump_d  = ($urandom_range(0, 3) == 0);
      br_d    = ($urandom_range(0, 2) == 0);
      stall_d = ($urandom_range(0, 3) == 0);
      rst_d   = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_d = 1'b1;
    idle_inputs();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
